// File: rtl/addsub_seq_ctrl.sv
// addsub_seq_ctrl: sequencing front end for an external rca_nb ripple-carry adder.
// Latches one signed add/subtract request per handshake, drives the adder for one
// cycle, captures sum/carry and two's-complement overflow, and holds the result
// until the consumer accepts it. A saturating counter tracks overflowed results.
// rst_n asserts asynchronously; its release is expected to be synchronous to clk.
module addsub_seq_ctrl #(
  parameter int N     = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     opa,
  input  logic [N-1:0]     opb,
  input  logic             op_sub,
  output logic [N-1:0]     add_a,
  output logic [N-1:0]     add_b,
  output logic             add_cin,
  input  logic [N-1:0]     add_sum,
  input  logic             add_co,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_sum,
  output logic             res_co,
  output logic             res_ovf,
  output logic [CNT_W-1:0] ovf_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic             s_q, s_d;
  logic [N-1:0]     sum_q, sum_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             res_valid_q, res_valid_d;

  // Signed overflow: operands (as presented to the adder) agree in sign but the sum does not.
  function automatic logic ovf_detect(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) & (s_msb != a_msb);
  endfunction

  // Next-state, operand latching, result capture and counter update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = opa;
          b_d     = op_sub ? ~opb : opb;
          s_d     = op_sub;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        sum_d = add_sum;
        co_d  = add_co;
        ovf_d = ovf_detect(a_q[N-1], b_q[N-1], add_sum[N-1]);
        if (ovf_d && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
        state_d = DONE;
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake flags are registered copies of the next state so they depend on state only.
    in_ready_d  = (state_d == IDLE);
    res_valid_d = (state_d == DONE);
  end

  // State, datapath and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= {N{1'b0}};
      b_q         <= {N{1'b0}};
      s_q         <= 1'b0;
      sum_q       <= {N{1'b0}};
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      sum_q       <= sum_d;
      co_q        <= co_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign add_a     = a_q;
  assign add_b     = b_q;
  assign add_cin   = s_q;
  assign res_sum   = sum_q;
  assign res_co    = co_q;
  assign res_ovf   = ovf_q;
  assign ovf_cnt   = cnt_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Testbench for addsub_seq_ctrl: models the rca_nb adder behaviourally and checks
// results against signed-integer arithmetic computed in the bench.
module tb_addsub_seq_ctrl;
  localparam int N     = 5;
  localparam int CNT_W = 8;
  localparam int CNT_MAX_I = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     opa;
  logic [N-1:0]     opb;
  logic             op_sub;
  logic [N-1:0]     add_a;
  logic [N-1:0]     add_b;
  logic             add_cin;
  logic [N-1:0]     add_sum;
  logic             add_co;
  logic             res_valid;
  logic             res_ready;
  logic [N-1:0]     res_sum;
  logic             res_co;
  logic             res_ovf;
  logic [CNT_W-1:0] ovf_cnt;
  logic [N:0]       add_total;

  int vectors     = 0;
  int miscompares = 0;
  int exp_cnt     = 0;

  addsub_seq_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opa(opa), .opb(opb), .op_sub(op_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_co(add_co),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_co(res_co), .res_ovf(res_ovf),
    .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  // Combinational stand-in for the rca_nb adder.
  assign add_total = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};
  assign add_sum   = add_total[N-1:0];
  assign add_co    = add_total[N];

  // Reference: signed arithmetic, overflow = out of range, carry = unsigned carry / no-borrow.
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                                output logic [N-1:0] s, output logic co, output logic ovf);
    int sa, sb, r, ua, ub;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    ua  = int'(a);
    ub  = int'(b);
    r   = sub ? (sa - sb) : (sa + sb);
    ovf = (r < -(1 << (N-1))) || (r > (1 << (N-1)) - 1);
    s   = r[N-1:0];
    co  = sub ? (ua >= ub) : ((ua + ub) > (1 << N) - 1);
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    opa = '0; opb = '0; op_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_cnt = 0;
    @(posedge clk); #1;
  endtask

  // One complete transaction; returns #1 after the edge that re-enters IDLE.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                        input int hold, input bit pulse);
    logic [N-1:0] es, eb;
    logic eco, eovf;
    model(a, b, sub, es, eco, eovf);
    eb = sub ? ~b : b;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL idle_ready: in_ready=%b required 1", in_ready);
    end
    opa = a; opb = b; op_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; opa = N'($urandom); opb = N'($urandom); op_sub = 1'($urandom);
    res_ready = 1'($urandom);
    vectors++;
    if ({in_ready, res_valid, add_a, add_b, add_cin} !== {1'b0, 1'b0, a, eb, sub}) begin
      miscompares++;
      $display("FAIL exec_drive: rdy/val/a/b/cin=%b/%b/%b/%b/%b required 0/0/%b/%b/%b",
               in_ready, res_valid, add_a, add_b, add_cin, a, eb, sub);
    end
    if (eovf && exp_cnt < CNT_MAX_I) exp_cnt++;
    @(posedge clk); #1;
    res_ready = 1'b0;
    vectors++;
    if ({in_ready, res_valid, res_sum, res_co, res_ovf, ovf_cnt} !==
        {1'b0, 1'b1, es, eco, eovf, CNT_W'(exp_cnt)}) begin
      miscompares++;
      $display("FAIL result %b%s%b: rdy/val/sum/co/ovf/cnt=%b/%b/%b/%b/%b/%0d required 0/1/%b/%b/%b/%0d",
               a, sub ? "-" : "+", b, in_ready, res_valid, res_sum, res_co, res_ovf, ovf_cnt,
               es, eco, eovf, exp_cnt);
    end
    for (int i = 0; i < hold; i++) begin
      if (pulse && i == hold / 2) begin
        opa = 5'b01111; opb = 5'b01111; op_sub = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      vectors++;
      if ({in_ready, res_valid, res_sum, res_co, res_ovf, ovf_cnt} !==
          {1'b0, 1'b1, es, eco, eovf, CNT_W'(exp_cnt)}) begin
        miscompares++;
        $display("FAIL hold cycle %0d: rdy/val/sum/co/ovf/cnt=%b/%b/%b/%b/%b/%0d required 0/1/%b/%b/%b/%0d",
                 i, in_ready, res_valid, res_sum, res_co, res_ovf, ovf_cnt, es, eco, eovf, exp_cnt);
      end
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    vectors++;
    if ({res_valid, in_ready, ovf_cnt} !== {1'b0, 1'b1, CNT_W'(exp_cnt)}) begin
      miscompares++;
      $display("FAIL release: val/rdy/cnt=%b/%b/%0d required 0/1/%0d",
               res_valid, in_ready, ovf_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({in_ready, res_valid, add_a, add_b, add_cin, res_sum, res_co, res_ovf, ovf_cnt} !==
        {1'b1, 1'b0, 5'b0, 5'b0, 1'b0, 5'b0, 1'b0, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%b val=%b a=%b b=%b cin=%b sum=%b co=%b ovf=%b cnt=%0d required 1,0,all zero",
               in_ready, res_valid, add_a, add_b, add_cin, res_sum, res_co, res_ovf, ovf_cnt);
    end
  endtask

  task automatic test_directed();
    run_op(5'b00111, 5'b00101, 1'b0, 0, 1'b0);  // 7+5
    run_op(5'b01100, 5'b00111, 1'b0, 0, 1'b0);  // 12+7 overflow
    run_op(5'b10000, 5'b00001, 1'b1, 0, 1'b0);  // -16-1 overflow
    run_op(5'b10000, 5'b10000, 1'b1, 0, 1'b0);  // -16-(-16)
    run_op(5'b00011, 5'b00101, 1'b1, 0, 1'b0);  // 3-5
    run_op(5'b00000, 5'b00000, 1'b1, 0, 1'b0);  // 0-0, carry set
    run_op(5'b00000, 5'b10000, 1'b1, 0, 1'b0);  // 0-(-16) overflow
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      run_op(N'($urandom), N'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end
  endtask

  task automatic test_backpressure();
    int cnt_before;
    cnt_before = exp_cnt;
    run_op(5'b00010, 5'b00011, 1'b0, 10, 1'b1);
    vectors++;
    if (int'(ovf_cnt) !== cnt_before) begin
      miscompares++;
      $display("FAIL ignored_request: ovf_cnt=%0d required %0d", ovf_cnt, cnt_before);
    end
    // IDLE must wait quietly for a fresh request.
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({in_ready, res_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL idle_after_release: rdy/val=%b/%b required 1/0", in_ready, res_valid);
    end
    run_op(5'b11111, 5'b00001, 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a, b, es;
    logic sub, eco, eovf;
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = N'($urandom); b = N'($urandom); sub = 1'($urandom);
      model(a, b, sub, es, eco, eovf);
      vectors++;
      if ({in_ready, res_valid} !== 2'b10) begin
        miscompares++;
        $display("FAIL b2b_idle %0d: rdy/val=%b/%b required 1/0", i, in_ready, res_valid);
      end
      opa = a; opb = b; op_sub = sub; in_valid = 1'b1;
      @(posedge clk); #1;
      opa = N'($urandom); opb = N'($urandom); op_sub = 1'($urandom);
      if (eovf && exp_cnt < CNT_MAX_I) exp_cnt++;
      @(posedge clk); #1;
      vectors++;
      if ({in_ready, res_valid, res_sum, res_co, res_ovf, ovf_cnt} !==
          {1'b0, 1'b1, es, eco, eovf, CNT_W'(exp_cnt)}) begin
        miscompares++;
        $display("FAIL b2b_result %0d: rdy/val/sum/co/ovf/cnt=%b/%b/%b/%b/%b/%0d required 0/1/%b/%b/%b/%0d",
                 i, in_ready, res_valid, res_sum, res_co, res_ovf, ovf_cnt, es, eco, eovf, exp_cnt);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    run_op(5'b01000, 5'b01000, 1'b0, 0, 1'b0);  // ensures counter is non-zero
    opa = 5'b01111; opb = 5'b00001; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, res_valid, add_a, add_b, add_cin, res_sum, res_co, res_ovf, ovf_cnt} !==
        {1'b1, 1'b0, 5'b0, 5'b0, 1'b0, 5'b0, 1'b0, 1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_mid: rdy=%b val=%b a=%b b=%b cin=%b sum=%b co=%b ovf=%b cnt=%0d required 1,0,all zero",
               in_ready, res_valid, add_a, add_b, add_cin, res_sum, res_co, res_ovf, ovf_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({in_ready, res_valid, ovf_cnt} !== {1'b1, 1'b0, 8'd0}) begin
        miscompares++;
        $display("FAIL after_reset %0d: rdy/val/cnt=%b/%b/%0d required 1/0/0", i, in_ready, res_valid, ovf_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      run_op(N'($urandom_range(8, 15)), N'($urandom_range(8, 15)), 1'b0, 0, 1'b0);
    end
    vectors++;
    if (ovf_cnt !== 8'hFF) begin
      miscompares++;
      $display("FAIL saturation: ovf_cnt=%0d required 255", ovf_cnt);
    end
    run_op(5'b10000, 5'b10000, 1'b0, 0, 1'b0);  // -16+-16 overflows, counter must hold
    run_op(5'b00001, 5'b00001, 1'b0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
